// File: rtl/pong_pkg.sv
// Shared types and constants for the pong match sequencer.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package pong_pkg;

    // Match sequencer states; encodings are exported on out_state.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_PLAY      = 3'd2,
        ST_PAUSED    = 3'd3,
        ST_SCORED    = 3'd4,
        ST_GAME_OVER = 3'd5
    } state_t;

    // Winner codes shown by the text overlay.
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    // ASCII score range produced by the ball block.
    localparam logic [7:0] ZERO_CHAR_DEF = 8'h30;
    localparam logic [7:0] LAST_CHAR_DEF = 8'h34;

    // Convert an ASCII score digit into a small binary score.
    function automatic logic [3:0] ascii_to_score(input logic [7:0] c);
        logic [7:0] w_diff;
        w_diff = c - ZERO_CHAR_DEF;
        return w_diff[3:0];
    endfunction

endpackage

// File: rtl/frame_tick_counter.sv
// Counts animation strobes and emits a one-cycle tick every FRAMES_PER_TICK strobes.
// Latency: tick is combinational on the strobe that completes the period.
// Backpressure: none; strobes are ignored while disabled or cleared, count is held while disabled.
module frame_tick_counter
    import pong_pkg::*;
#(
    parameter int FRAMES_PER_TICK = 60
) (
    input  logic in_clock,
    input  logic in_reset,
    input  logic in_ani_stb,
    input  logic in_clear,
    input  logic in_enable,
    output logic out_tick
);

    localparam int W = (FRAMES_PER_TICK > 1) ? $clog2(FRAMES_PER_TICK) : 1;
    localparam logic [W-1:0] LAST_FRAME = W'(FRAMES_PER_TICK - 1);

    logic [W-1:0] r_frame_cnt;
    logic         w_step;

    assign w_step   = in_enable && in_ani_stb && !in_clear;
    assign out_tick = w_step && (r_frame_cnt == LAST_FRAME);

    // Frame counter: clear wins, otherwise advance on enabled strobes and wrap at the period.
    always_ff @(posedge in_clock) begin
        if (in_reset || in_clear) begin
            r_frame_cnt <= '0;
        end else if (w_step) begin
            if (r_frame_cnt == LAST_FRAME) begin
                r_frame_cnt <= '0;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pong_match_ctrl.sv
// Match sequencer: serve countdown, play/pause, point and match-end detection, game-over hold.
// Latency: all outputs registered; score change to count_vis high takes 2 cycles.
// Backpressure: none; button pulses outside the states that use them are dropped.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int         FRAMES_PER_TICK = 60,
    parameter logic [3:0] COUNT_FROM      = 4'd3,   // must be non-zero
    parameter int         OVER_TICKS      = 5,
    parameter logic [7:0] ZERO_CHAR       = ZERO_CHAR_DEF,
    parameter logic [7:0] LAST_CHAR       = LAST_CHAR_DEF
) (
    input  logic       in_clock,
    input  logic       in_reset,
    input  logic       in_ani_stb,
    input  logic       in_btn_start,
    input  logic       in_btn_pause,
    input  logic [7:0] in_player1,
    input  logic [7:0] in_player2,
    output logic       out_ball_reset,
    output logic       out_ball_start,
    output logic       out_animate,
    output logic [2:0] out_state,
    output logic [3:0] out_count,
    output logic       out_count_vis,
    output logic [1:0] out_winner
);

    localparam logic [3:0] LAST_OVER_TICK = 4'(OVER_TICKS - 1);

    state_t     r_state;
    logic [7:0] r_p1_q;
    logic [7:0] r_p2_q;
    logic [3:0] r_tick_cnt;
    logic [3:0] r_count;
    logic [1:0] r_winner;
    logic       r_ball_reset;
    logic       r_ball_start;
    logic       r_animate;
    logic       r_count_vis;

    logic       w_tick;
    logic       w_fc_clear;
    logic       w_fc_enable;
    logic       w_new_match;
    logic       w_game_end;
    logic       w_point;

    // A start press only means something while no match is running.
    assign w_new_match = in_btn_start && ((r_state == ST_IDLE) || (r_state == ST_GAME_OVER));

    // The ball resets both scores to zero after the deciding point, so a
    // return to 0/0 while a shadow sits at the last digit marks match end.
    assign w_game_end = (in_player1 == ZERO_CHAR) && (in_player2 == ZERO_CHAR) &&
                        ((r_p1_q == LAST_CHAR) || (r_p2_q == LAST_CHAR));
    assign w_point    = (in_player1 != r_p1_q) || (in_player2 != r_p2_q);

    // The frame counter runs only for countdown and game-over timing. It is
    // cleared in states that precede a timed state (and on a restart from
    // game-over) so every timed phase starts at frame zero; it is left
    // untouched while paused.
    assign w_fc_enable = (r_state == ST_COUNTDOWN) || (r_state == ST_GAME_OVER);
    assign w_fc_clear  = (r_state == ST_IDLE) || (r_state == ST_PLAY) ||
                         (r_state == ST_SCORED) ||
                         ((r_state == ST_GAME_OVER) && in_btn_start);

    frame_tick_counter #(
        .FRAMES_PER_TICK(FRAMES_PER_TICK)
    ) u_frame_tick (
        .in_clock   (in_clock),
        .in_reset   (in_reset),
        .in_ani_stb (in_ani_stb),
        .in_clear   (w_fc_clear),
        .in_enable  (w_fc_enable),
        .out_tick   (w_tick)
    );

    // Match FSM with registered outputs; pulses default low every cycle so
    // they can never stretch, since each is only raised on a state change.
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            r_state      <= ST_IDLE;
            r_ball_reset <= 1'b1;
            r_ball_start <= 1'b0;
            r_animate    <= 1'b0;
            r_count      <= 4'd0;
            r_count_vis  <= 1'b0;
            r_winner     <= WIN_NONE;
            r_p1_q       <= ZERO_CHAR;
            r_p2_q       <= ZERO_CHAR;
            r_tick_cnt   <= 4'd0;
        end else begin
            r_ball_reset <= 1'b0;
            r_ball_start <= 1'b0;

            if (w_new_match) begin
                // Reset the ball (scores back to zero) and begin the first serve countdown.
                r_ball_reset <= 1'b1;
                r_winner     <= WIN_NONE;
                r_count      <= COUNT_FROM;
                r_count_vis  <= 1'b1;
                r_animate    <= 1'b1;
                r_p1_q       <= ZERO_CHAR;
                r_p2_q       <= ZERO_CHAR;
                r_state      <= ST_COUNTDOWN;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_animate   <= 1'b0;
                        r_count_vis <= 1'b0;
                    end

                    ST_COUNTDOWN: begin
                        // Animate stays on: the ball holds its own position until started.
                        if (w_tick) begin
                            if (r_count == 4'd1) begin
                                r_count      <= 4'd0;
                                r_count_vis  <= 1'b0;
                                r_ball_start <= 1'b1;
                                r_state      <= ST_PLAY;
                            end else begin
                                r_count <= r_count - 4'd1;
                            end
                        end
                    end

                    ST_PLAY: begin
                        // Score events take priority over a pause in the same cycle.
                        if (w_game_end) begin
                            r_winner   <= (r_p1_q == LAST_CHAR) ? WIN_P1 : WIN_P2;
                            r_p1_q     <= in_player1;
                            r_p2_q     <= in_player2;
                            r_animate  <= 1'b0;
                            r_tick_cnt <= 4'd0;
                            r_state    <= ST_GAME_OVER;
                        end else if (w_point) begin
                            r_p1_q  <= in_player1;
                            r_p2_q  <= in_player2;
                            r_state <= ST_SCORED;
                        end else if (in_btn_pause) begin
                            r_animate <= 1'b0;
                            r_state   <= ST_PAUSED;
                        end
                    end

                    ST_PAUSED: begin
                        // Ball is frozen, so score inputs are not examined here.
                        if (in_btn_pause) begin
                            r_animate <= 1'b1;
                            r_state   <= ST_PLAY;
                        end
                    end

                    ST_SCORED: begin
                        r_count     <= COUNT_FROM;
                        r_count_vis <= 1'b1;
                        r_animate   <= 1'b1;
                        r_state     <= ST_COUNTDOWN;
                    end

                    ST_GAME_OVER: begin
                        // Hold the result for OVER_TICKS ticks, then fall back to idle.
                        if (w_tick) begin
                            if (r_tick_cnt == LAST_OVER_TICK) begin
                                r_winner <= WIN_NONE;
                                r_state  <= ST_IDLE;
                            end else begin
                                r_tick_cnt <= r_tick_cnt + 4'd1;
                            end
                        end
                    end

                    default: begin
                        r_animate   <= 1'b0;
                        r_count_vis <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign out_ball_reset = r_ball_reset;
    assign out_ball_start = r_ball_start;
    assign out_animate    = r_animate;
    assign out_state      = r_state;
    assign out_count      = r_count;
    assign out_count_vis  = r_count_vis;
    assign out_winner     = r_winner;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Self-checking bench for pong_match_ctrl: directed scenarios then random play,
// every cycle compared against a strobe-counting reference model and a tiny ball model.
module tb_pong_match_ctrl;

    localparam int         FPT = 2;
    localparam int         CF  = 3;
    localparam int         OT  = 5;
    localparam logic [7:0] ZC  = 8'h30;
    localparam logic [7:0] LC  = 8'h34;

    logic       clk = 1'b0;
    logic       rst;
    logic       ani;
    logic       bst;
    logic       bpz;
    logic [7:0] p1;
    logic [7:0] p2;
    logic       o_brst;
    logic       o_bstart;
    logic       o_anim;
    logic [2:0] o_state;
    logic [3:0] o_count;
    logic       o_vis;
    logic [1:0] o_win;

    always #5 clk = ~clk;

    pong_match_ctrl #(
        .FRAMES_PER_TICK(FPT),
        .COUNT_FROM     (4'(CF)),
        .OVER_TICKS     (OT),
        .ZERO_CHAR      (ZC),
        .LAST_CHAR      (LC)
    ) dut (
        .in_clock       (clk),
        .in_reset       (rst),
        .in_ani_stb     (ani),
        .in_btn_start   (bst),
        .in_btn_pause   (bpz),
        .in_player1     (p1),
        .in_player2     (p2),
        .out_ball_reset (o_brst),
        .out_ball_start (o_bstart),
        .out_animate    (o_anim),
        .out_state      (o_state),
        .out_count      (o_count),
        .out_count_vis  (o_vis),
        .out_winner     (o_win)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: phase number, and strobes seen since the current timed phase began.
    int m_state, m_count, m_vis, m_anim, m_win, m_brst, m_bstart, m_strobes;
    logic [7:0] m_sh1, m_sh2;
    // Ball model: current ASCII scores.
    logic [7:0] b1, b2;

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        n_chk++;
        if (got !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_step(input bit st, input bit pz, input bit stb, input bit rs,
                              input logic [7:0] i1, input logic [7:0] i2);
        m_brst   = 0;
        m_bstart = 0;
        if (rs) begin
            m_state = 0; m_brst = 1; m_count = 0; m_vis = 0; m_anim = 0; m_win = 0;
            m_sh1 = ZC; m_sh2 = ZC; m_strobes = 0;
        end else if (st && (m_state == 0 || m_state == 5)) begin
            m_brst = 1; m_win = 0; m_count = CF; m_vis = 1; m_anim = 1;
            m_strobes = 0; m_sh1 = ZC; m_sh2 = ZC; m_state = 1;
        end else begin
            case (m_state)
                1: if (stb) begin
                    m_strobes++;
                    m_count = CF - m_strobes / FPT;
                    if (m_count == 0) begin
                        m_bstart = 1; m_vis = 0; m_state = 2;
                    end
                end
                2: begin
                    if (i1 == ZC && i2 == ZC && (m_sh1 == LC || m_sh2 == LC)) begin
                        m_win = (m_sh1 == LC) ? 1 : 2;
                        m_sh1 = i1; m_sh2 = i2; m_anim = 0; m_strobes = 0; m_state = 5;
                    end else if (i1 != m_sh1 || i2 != m_sh2) begin
                        m_sh1 = i1; m_sh2 = i2; m_state = 4;
                    end else if (pz) begin
                        m_anim = 0; m_state = 3;
                    end
                end
                3: if (pz) begin
                    m_anim = 1; m_state = 2;
                end
                4: begin
                    m_count = CF; m_vis = 1; m_strobes = 0; m_state = 1;
                end
                5: if (stb) begin
                    m_strobes++;
                    if (m_strobes == OT * FPT) begin
                        m_win = 0; m_state = 0;
                    end
                end
                default: ;
            endcase
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare all outputs just after.
    task automatic cycle(input bit st, input bit pz, input bit rs);
        rst = rs; bst = st; bpz = pz;
        ani = ((cyc % 4) == 3);
        p1 = b1; p2 = b2;
        @(posedge clk);
        model_step(st, pz, ani, rs, b1, b2);
        cyc++;
        #1;
        chk("state",      32'(o_state),  m_state);
        chk("count",      32'(o_count),  m_count);
        chk("count_vis",  32'(o_vis),    m_vis);
        chk("animate",    32'(o_anim),   m_anim);
        chk("winner",     32'(o_win),    m_win);
        chk("ball_reset", 32'(o_brst),   m_brst);
        chk("ball_start", 32'(o_bstart), m_bstart);
        if (m_brst != 0) begin
            b1 = ZC; b2 = ZC;
        end
    endtask

    // Ball awards a point; the deciding point returns both scores to zero.
    task automatic point(input int who);
        if (who == 1) begin
            if (b1 == LC) begin b1 = ZC; b2 = ZC; end else b1 = b1 + 8'd1;
        end else begin
            if (b2 == LC) begin b1 = ZC; b2 = ZC; end else b2 = b2 + 8'd1;
        end
    endtask

    task automatic wait_state(input int tgt, input int lim, input string tag);
        int k = 0;
        while (m_state != tgt && k < lim) begin
            cycle(0, 0, 0);
            k++;
        end
        chk(tag, 32'(o_state), tgt);
    endtask

    initial begin
        int k;
        rst = 1; ani = 0; bst = 0; bpz = 0; b1 = ZC; b2 = ZC; p1 = ZC; p2 = ZC;
        m_state = 0; m_count = 0; m_vis = 0; m_anim = 0; m_win = 0;
        m_brst = 0; m_bstart = 0; m_strobes = 0; m_sh1 = ZC; m_sh2 = ZC;

        // Reset state and ball reset pulse.
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        chk("reset_ball_reset", 32'(o_brst), 1);
        cycle(0, 0, 0);
        chk("idle_ball_reset_low", 32'(o_brst), 0);

        // Start a match and run the serve countdown.
        cycle(1, 0, 0);
        chk("start_count", 32'(o_count), 3);
        wait_state(2, 200, "countdown_to_play");

        // Point and pause in the same cycle: the point wins.
        cycle(0, 0, 0);
        point(1);
        cycle(0, 1, 0);
        chk("score_beats_pause", 32'(o_state), 4);
        cycle(0, 0, 0);
        chk("scored_to_countdown", 32'(o_state), 1);
        chk("scored_count_reload", 32'(o_count), 3);
        wait_state(2, 200, "recount_to_play");

        // Pause, let strobes pass, resume.
        cycle(0, 1, 0);
        chk("paused_state", 32'(o_state), 3);
        repeat (40) cycle(0, 0, 0);
        chk("paused_hold", 32'(o_state), 3);
        cycle(0, 1, 0);
        chk("resume_animate", 32'(o_anim), 1);

        // Player 2 runs to the last digit, then takes the deciding point.
        for (int i = 0; i < 4; i++) begin
            point(2);
            cycle(0, 0, 0);
            wait_state(2, 200, "p2_point_replay");
        end
        point(2);
        cycle(0, 0, 0);
        chk("game_over_state", 32'(o_state), 5);
        chk("game_over_winner", 32'(o_win), 2);
        wait_state(0, 200, "over_to_idle");
        chk("idle_winner_clear", 32'(o_win), 0);

        // Reset in the middle of the countdown.
        cycle(1, 0, 0);
        k = 0;
        while (m_count != 2 && k < 100) begin
            cycle(0, 0, 0);
            k++;
        end
        chk("mid_countdown_count", 32'(o_count), 2);
        cycle(0, 0, 1);
        chk("mid_reset_state", 32'(o_state), 0);
        chk("mid_reset_count", 32'(o_count), 0);
        repeat (30) cycle(0, 0, 0);
        chk("no_start_after_reset", 32'(o_state), 0);

        // Random play.
        repeat (5000) begin
            bit st, pz, rs;
            st = ($urandom_range(0, 39) == 0);
            pz = ($urandom_range(0, 19) == 0);
            rs = ($urandom_range(0, 299) == 0);
            if (m_state == 2 && $urandom_range(0, 7) == 0) point(int'($urandom_range(1, 2)));
            cycle(st, pz, rs);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
